// File: rtl/fix2flt_pkg.sv
// Shared types and helpers for the fixed-point to float converter.
package fix2flt_pkg;

    // Conversion sequence, one state per pipeline step.
    typedef enum logic [2:0] {
        StIdle,
        StLzc,
        StNorm,
        StRound,
        StDone
    } state_e;

    // Only round-to-nearest-even is implemented; the field is kept for future modes.
    typedef enum logic [0:0] {
        RndNearestEven
    } round_mode_e;

    localparam round_mode_e RoundMode = RndNearestEven;

    // Exponent bias for an IEEE-754-style format with the given exponent width.
    function automatic int unsigned calc_bias(input int unsigned exp_width);
        return (32'd1 << (exp_width - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/lzc.sv
// Combinational leading-zero counter; all-zero input yields WIDTH.
module lzc #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]         data_i,
    output logic [$clog2(WIDTH+1)-1:0] count_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    // Scan upward so the highest set bit wins.
    always_comb begin
        count_o = CntW'(WIDTH);
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (data_i[i]) begin
                count_o = CntW'(int'(WIDTH) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fix_to_float_conv.sv
// Fixed-point (signed or unsigned) to IEEE-754-style float converter with
// round-to-nearest-even and valid/ready handshakes on both sides.
// Optional macro FIX2FLT_INEXACT_EN adds a registered 'inexact' output.
module fix_to_float_conv
    import fix2flt_pkg::*;
#(
    parameter int unsigned INT_WIDTH   = 12,
    parameter int unsigned FRACT_WIDTH = 4,
    parameter int unsigned SIGNED      = 1,
    parameter int unsigned EXP_WIDTH   = 8,
    parameter int unsigned MAN_WIDTH   = 23
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              valid_in,
    output logic                              ready_in,
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0]  fixed_point,
    output logic                              valid_out,
    input  logic                              ready_out,
`ifdef FIX2FLT_INEXACT_EN
    output logic                              inexact,
`endif
    output logic [EXP_WIDTH+MAN_WIDTH:0]      data_out
);

    localparam int unsigned W    = INT_WIDTH + FRACT_WIDTH;
    localparam int unsigned FW   = W - 1;
    localparam int unsigned LzW  = $clog2(W + 1);
    localparam int unsigned Bias = calc_bias(EXP_WIDTH);
    localparam int unsigned ExpW = EXP_WIDTH + 2;

    // Exponent cannot leave the normal range only when the bias dominates both widths.
    if (Bias <= INT_WIDTH || Bias <= FRACT_WIDTH || W < 2) begin : g_param_check
        $error("fix_to_float_conv: BIAS must exceed INT_WIDTH and FRACT_WIDTH");
    end
    if (RoundMode != RndNearestEven) begin : g_round_check
        $error("fix_to_float_conv: only round-to-nearest-even is supported");
    end

    state_e                 state_q, state_d;
    logic [W-1:0]           op_q, op_d;
    logic                   sign_q, sign_d;
    logic [W-1:0]           mag_q, mag_d;
    logic [LzW-1:0]         lz_q, lz_d;
    logic [W-1:0]           norm_q, norm_d;
    logic signed [ExpW-1:0] exp_q, exp_d;
    logic                   ready_in_q, ready_in_d;
    logic                   valid_out_q, valid_out_d;
    logic [EXP_WIDTH+MAN_WIDTH:0] data_out_q, data_out_d;

    logic                   sign_c;
    logic [W-1:0]           mag_c;
    logic [LzW-1:0]         lz_c;
    logic [MAN_WIDTH-1:0]   man_c;
    logic                   round_up_c;
    logic [MAN_WIDTH:0]     man_sum;
    logic signed [ExpW-1:0] exp_final;
    logic                   unused_exp_msb;

    lzc #(
        .WIDTH (W)
    ) u_lzc (
        .data_i  (mag_c),
        .count_o (lz_c)
    );

    // Sign/magnitude split; negating the most-negative value wraps to 2^(W-1) as intended.
    always_comb begin
        sign_c = (SIGNED != 0) ? op_q[W-1] : 1'b0;
        mag_c  = sign_c ? W'(-op_q) : op_q;
    end

    if (FW <= MAN_WIDTH) begin : g_exact
        // Whole fraction fits: left-align it into the mantissa.
        always_comb begin
            man_c      = MAN_WIDTH'(norm_q[W-2:0]) << (MAN_WIDTH - FW);
            round_up_c = 1'b0;
        end
`ifdef FIX2FLT_INEXACT_EN
        logic inexact_c;
        assign inexact_c = 1'b0;
`endif
    end else begin : g_rne
        localparam int unsigned Drop = FW - MAN_WIDTH;
        logic [FW-1:0] frac;
        logic          guard;
        logic          sticky;
        // Truncate to the mantissa, then round to nearest even from guard/sticky.
        always_comb begin
            frac       = norm_q[W-2:0];
            man_c      = frac[FW-1 -: MAN_WIDTH];
            guard      = frac[Drop-1];
            sticky     = |(frac & ((FW'(1) << (Drop - 1)) - FW'(1)));
            round_up_c = guard & (sticky | man_c[0]);
        end
`ifdef FIX2FLT_INEXACT_EN
        logic inexact_c;
        assign inexact_c = guard | sticky;
`endif
    end

    // Mantissa increment; a carry out renormalises into the exponent with man=0.
    always_comb begin
        man_sum        = {1'b0, man_c} + (MAN_WIDTH + 1)'(round_up_c);
        exp_final      = exp_q + ExpW'(man_sum[MAN_WIDTH]);
        unused_exp_msb = ^exp_final[ExpW-1:EXP_WIDTH];
    end

`ifdef FIX2FLT_INEXACT_EN
    logic inexact_q, inexact_d;
    logic inexact_round;
    if (FW <= MAN_WIDTH) begin : g_inx_sel_exact
        assign inexact_round = g_exact.inexact_c;
    end else begin : g_inx_sel_rne
        assign inexact_round = g_rne.inexact_c;
    end
`endif

    // Next-state and datapath register updates for each conversion step.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        lz_d        = lz_q;
        norm_d      = norm_q;
        exp_d       = exp_q;
        ready_in_d  = ready_in_q;
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
`ifdef FIX2FLT_INEXACT_EN
        inexact_d   = inexact_q;
`endif
        unique case (state_q)
            StIdle: begin
                ready_in_d = 1'b1;
                if (valid_in && ready_in_q) begin
                    op_d       = fixed_point;
                    ready_in_d = 1'b0;
                    state_d    = StLzc;
                end
            end
            StLzc: begin
                sign_d  = sign_c;
                mag_d   = mag_c;
                lz_d    = lz_c;
                state_d = StNorm;
            end
            StNorm: begin
                norm_d  = mag_q << lz_q;
                exp_d   = $signed(ExpW'(Bias + INT_WIDTH - 1) - ExpW'(lz_q));
                state_d = StRound;
            end
            StRound: begin
                valid_out_d = 1'b1;
                // A normalised non-zero magnitude always has its MSB set.
                data_out_d  = norm_q[W-1] ?
                              {sign_q, exp_final[EXP_WIDTH-1:0], man_sum[MAN_WIDTH-1:0]} : '0;
`ifdef FIX2FLT_INEXACT_EN
                inexact_d   = norm_q[W-1] & inexact_round;
`endif
                state_d     = StDone;
            end
            StDone: begin
                if (ready_out) begin
                    valid_out_d = 1'b0;
                    ready_in_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= '0;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            lz_q        <= '0;
            norm_q      <= '0;
            exp_q       <= '0;
            ready_in_q  <= 1'b0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
`ifdef FIX2FLT_INEXACT_EN
            inexact_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            lz_q        <= lz_d;
            norm_q      <= norm_d;
            exp_q       <= exp_d;
            ready_in_q  <= ready_in_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
`ifdef FIX2FLT_INEXACT_EN
            inexact_q   <= inexact_d;
`endif
        end
    end

    assign ready_in  = ready_in_q;
    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
`ifdef FIX2FLT_INEXACT_EN
    assign inexact   = inexact_q;
`endif

endmodule

// File: tb/tb_fix_to_float_conv.sv
// Bench for fix_to_float_conv: three instances (12.4 signed, 16.16 signed, 12.4 unsigned)
// driven in lock-step and compared against an arithmetic reference model.
module tb_fix_to_float_conv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] fx;
    logic        rdy_a, rdy_b, rdy_c;
    logic        vld_a, vld_b, vld_c;
    logic [31:0] dat_a, dat_b, dat_c;
`ifdef FIX2FLT_INEXACT_EN
    logic        inx_a, inx_b, inx_c;
`endif

    int errors = 0;
    int checks = 0;

    fix_to_float_conv #(
        .INT_WIDTH(12), .FRACT_WIDTH(4), .SIGNED(1), .EXP_WIDTH(8), .MAN_WIDTH(23)
    ) u_a (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(rdy_a),
        .fixed_point(fx[15:0]), .valid_out(vld_a), .ready_out(ready_out),
`ifdef FIX2FLT_INEXACT_EN
        .inexact(inx_a),
`endif
        .data_out(dat_a)
    );

    fix_to_float_conv #(
        .INT_WIDTH(16), .FRACT_WIDTH(16), .SIGNED(1), .EXP_WIDTH(8), .MAN_WIDTH(23)
    ) u_b (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(rdy_b),
        .fixed_point(fx), .valid_out(vld_b), .ready_out(ready_out),
`ifdef FIX2FLT_INEXACT_EN
        .inexact(inx_b),
`endif
        .data_out(dat_b)
    );

    fix_to_float_conv #(
        .INT_WIDTH(12), .FRACT_WIDTH(4), .SIGNED(0), .EXP_WIDTH(8), .MAN_WIDTH(23)
    ) u_c (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(rdy_c),
        .fixed_point(fx[15:0]), .valid_out(vld_c), .ready_out(ready_out),
`ifdef FIX2FLT_INEXACT_EN
        .inexact(inx_c),
`endif
        .data_out(dat_c)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Value of the fixed-point operand as fp32, using plain integer arithmetic.
    // Bit 32 of the result is the inexact flag.
    function automatic logic [32:0] model(input logic [31:0] raw, input int iw, input int fw,
                                          input bit sgn);
        int w, p, e, sh;
        longint unsigned v, mag, q, rem, half;
        bit s, inx;
        w = iw + fw;
        v = {32'd0, raw} & ((64'd1 << w) - 64'd1);
        s = sgn && v[w-1];
        mag = s ? (64'd1 << w) - v : v;
        if (mag == 0) return '0;
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        e = 127 + p - fw;
        inx = 1'b0;
        if (p <= 23) begin
            q = mag << (23 - p);
        end else begin
            sh   = p - 23;
            q    = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            inx  = (rem != 0);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q[24]) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        return {inx, s, e[7:0], q[22:0]};
    endfunction

    // Transaction-level expectation: ready/valid timing and the pending results.
    bit          started = 1'b0;
    bit          m_ready = 1'b0;
    bit          m_valid = 1'b0;
    int          m_cnt = 0;
    logic [32:0] p_a, p_b, p_c, e_a, e_b, e_c;

    always @(posedge clk) begin
        if (rst) begin
            started <= 1'b1;
            m_ready <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_valid <= 1'b1;
                e_a <= p_a;
                e_b <= p_b;
                e_c <= p_c;
            end
        end else if (m_valid) begin
            if (ready_out) begin
                m_valid <= 1'b0;
                m_ready <= 1'b1;
            end
        end else if (m_ready) begin
            if (valid_in) begin
                m_ready <= 1'b0;
                m_cnt   <= 3;
                p_a <= model(fx, 12, 4, 1'b1);
                p_b <= model(fx, 16, 16, 1'b1);
                p_c <= model(fx, 12, 4, 1'b0);
            end
        end else begin
            m_ready <= 1'b1;
        end
    end

    // Every cycle: handshake outputs always, result fields whenever valid.
    always @(negedge clk) begin
        if (started) begin
            check("ready_in_a", rdy_a, m_ready);
            check("ready_in_b", rdy_b, m_ready);
            check("ready_in_c", rdy_c, m_ready);
            check("valid_out_a", vld_a, m_valid);
            check("valid_out_b", vld_b, m_valid);
            check("valid_out_c", vld_c, m_valid);
            if (m_valid) begin
                check("data_a", dat_a, e_a[31:0]);
                check("data_b", dat_b, e_b[31:0]);
                check("data_c", dat_c, e_c[31:0]);
`ifdef FIX2FLT_INEXACT_EN
                check("inexact_a", inx_a, e_a[32]);
                check("inexact_b", inx_b, e_b[32]);
                check("inexact_c", inx_c, e_c[32]);
`endif
            end
        end
    end

    // Present one operand when the converter is ready; returns on the negedge after acceptance.
    task automatic send(input logic [31:0] val);
        int n = 0;
        while (!m_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) check("send_timeout", 64'd0, 64'd1);
        fx = val;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        fx = $urandom;
    endtask

    // Waits for valid_out; reports edges elapsed after the accepting edge.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!vld_a && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        if (!vld_a) check("valid_timeout", 64'd0, 64'd1);
    endtask

    logic [31:0] dir_val [9];
    int          dir_dut [9];
    logic [31:0] dir_exp [9];
    logic [31:0] act;
    logic [31:0] hold_a, hold_b;
    int          edges;
    int          sel;

    initial begin
        dir_val = '{32'h0010, 32'hFFF0, 32'h0000, 32'h8000, 32'h7FFF,
                    32'h8000, 32'h0100_0001, 32'h0100_0003, 32'h01FF_FFFF};
        dir_dut = '{0, 0, 0, 0, 0, 2, 1, 1, 1};
        // 2047.9375 = 1.11111111111111b * 2^10 -> mantissa 0x7FFE00
        dir_exp = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'hC500_0000, 32'h44FF_FE00,
                    32'h4500_0000, 32'h4380_0000, 32'h4380_0002, 32'h4400_0000};

        rst = 1'b1;
        valid_in = 1'b0;
        ready_out = 1'b1;
        fx = '0;
        repeat (3) @(negedge clk);
        check("reset_valid_out", vld_a, 64'd0);
        check("reset_data_out", dat_a, 64'd0);
        check("reset_ready_in", rdy_a, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", rdy_a, 64'd1);

        // Directed vectors with hand-computed results.
        for (int i = 0; i < 9; i++) begin
            send(dir_val[i]);
            wait_valid(edges);
            check("latency", edges, 64'd3);
            sel = dir_dut[i];
            act = (sel == 0) ? dat_a : (sel == 1) ? dat_b : dat_c;
            check($sformatf("directed_%0d", i), act, dir_exp[i]);
`ifdef FIX2FLT_INEXACT_EN
            if (sel == 1) check($sformatf("directed_inexact_%0d", i), inx_b, 64'd1);
`endif
            @(negedge clk);
        end

        // Backpressure: output frozen, input ignored.
        ready_out = 1'b0;
        send(32'h0000_0123);
        wait_valid(edges);
        hold_a = dat_a;
        hold_b = dat_b;
        for (int i = 0; i < 10; i++) begin
            fx = $urandom;
            valid_in = 1'b1;
            @(negedge clk);
            check("bp_valid", vld_a, 64'd1);
            check("bp_data_a", dat_a, hold_a);
            check("bp_data_b", dat_b, hold_b);
            check("bp_ready_in", rdy_a, 64'd0);
        end
        valid_in = 1'b0;
        ready_out = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid_out", vld_a, 64'd0);
        check("release_ready_in", rdy_a, 64'd1);
        @(negedge clk);

        // Reset during NORM aborts the conversion.
        send(32'h0000_0050);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid_out", vld_a, 64'd0);
        check("abort_data_out", dat_a, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_output", vld_a, 64'd0);
        end

        // Random traffic with random backpressure.
        for (int i = 0; i < 3000; i++) begin
            valid_in = 1'($urandom_range(0, 1));
            ready_out = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: fx = $urandom;
                1: fx = 32'($urandom_range(0, 255));
                2: begin
                    case ($urandom_range(0, 5))
                        0: fx = 32'h0000_8000;
                        1: fx = 32'h0000_7FFF;
                        2: fx = 32'h8000_0000;
                        3: fx = 32'h7FFF_FFFF;
                        4: fx = 32'hFFFF_FFFF;
                        default: fx = 32'h0000_0000;
                    endcase
                end
                default: fx = 32'h0100_0000 | ($urandom & 32'h00FF_FFFF);
            endcase
            @(negedge clk);
        end
        valid_in = 1'b0;
        ready_out = 1'b1;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
